// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface addsub_serial_if #(
  parameter int W = 4
);
  logic                start;
  logic                sub;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                busy;
  logic                done;
  logic signed [W:0]   sum;
  logic                cout;
  logic                ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// plus one sign-extension step yielding an exact (W+1)-bit result.
module addsub_serial #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] MSB_STEP = CW'(W - 1);
  localparam logic [CW-1:0] EXT_STEP = CW'(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] a_sr_q, a_sr_d;
  logic signed [W-1:0] b_sr_q, b_sr_d;
  logic [W:0]          res_q, res_d;
  logic                c_q, c_d;
  logic                cin_msb_q, cin_msb_d;
  logic                cout_msb_q, cout_msb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic signed [W:0]   sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic rbit, cnext;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign rbit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign cnext = maj(a_sr_q[0], b_sr_q[0], c_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_d      = res_q;
    c_d        = c_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    busy_d     = busy_q;
    done_d     = done_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;

    case (state_q)
      RUN: begin
        res_d = {rbit, res_q[W:1]};
        if (cnt_q == EXT_STEP) begin
          // Carry out of the MSB feeds the extra bit so the W+1 result is exact
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = $signed({rbit, res_q[W:1]});
          cout_d  = cout_msb_q;
          ovf_d   = cin_msb_q ^ cout_msb_q;
        end else begin
          // Arithmetic shift keeps the MSBs in bit 0 for the extension step
          a_sr_d = a_sr_q >>> 1;
          b_sr_d = b_sr_q >>> 1;
          c_d    = cnext;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == MSB_STEP) begin
            cin_msb_d  = c_q;
            cout_msb_d = cnext;
          end
        end
      end
      default: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b ^ {W{bus.sub}};
          c_d     = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_q      <= '0;
      c_q        <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_q      <= res_d;
      c_q        <= c_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed vectors, corner sequences and random ops
// at W=4 and W=8 against an integer-arithmetic reference model.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.W(4)) i4 ();
  addsub_serial_if #(.W(8)) i8 ();

  addsub_serial #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  addsub_serial #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic              s;
    int                es;
    bit                ec;
    bit                eo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, carry from unsigned addition of the
  // operand bit patterns, overflow when the true result leaves W-bit range.
  function automatic void model(input int w, input longint av, input longint bv, input bit s,
                                output longint es, output bit ec, output bit eo);
    longint mask, ua, ub;
    mask = (longint'(1) << w) - 1;
    es   = s ? av - bv : av + bv;
    ua   = av & mask;
    ub   = (s ? ~bv : bv) & mask;
    ec   = (((ua + ub + longint'(s)) >> w) & 1) != 0;
    eo   = (es > ((longint'(1) << (w - 1)) - 1)) || (es < -(longint'(1) << (w - 1)));
  endfunction

  task automatic op4(input logic signed [3:0] av, input logic signed [3:0] bv, input logic s,
                     output longint rs, output bit rc, output bit ro, output int edges);
    @(negedge clk);
    i4.start = 1'b1; i4.a = av; i4.b = bv; i4.sub = s;
    @(posedge clk); #1;
    i4.start = 1'b0;
    chk("busy4_after_start", longint'(i4.busy), 1);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (i4.done) break;
    end
    rs = longint'(i4.sum); rc = i4.cout; ro = i4.ovf;
  endtask

  task automatic op8(input logic signed [7:0] av, input logic signed [7:0] bv, input logic s,
                     output longint rs, output bit rc, output bit ro, output int edges);
    @(negedge clk);
    i8.start = 1'b1; i8.a = av; i8.b = bv; i8.sub = s;
    @(posedge clk); #1;
    i8.start = 1'b0;
    edges = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (i8.done) break;
    end
    rs = longint'(i8.sum); rc = i8.cout; ro = i8.ovf;
  endtask

  initial begin
    longint rs, es;
    bit rc, ro, ec, eo;
    int edges, seen_done;
    logic signed [3:0] ra, rb;
    logic signed [7:0] qa, qb;
    logic rsub;

    tbl[0] = '{a: 4'sd5,  b: 4'sd3,  s: 1'b0, es: 8,   ec: 1'b0, eo: 1'b1};
    tbl[1] = '{a: 4'sd3,  b: 4'sd5,  s: 1'b1, es: -2,  ec: 1'b0, eo: 1'b0};
    tbl[2] = '{a: -4'sd8, b: 4'sd1,  s: 1'b1, es: -9,  ec: 1'b1, eo: 1'b1};
    tbl[3] = '{a: 4'sd7,  b: 4'sd7,  s: 1'b1, es: 0,   ec: 1'b1, eo: 1'b0};
    tbl[4] = '{a: -4'sd8, b: -4'sd8, s: 1'b0, es: -16, ec: 1'b1, eo: 1'b1};
    tbl[5] = '{a: -4'sd1, b: 4'sd1,  s: 1'b0, es: 0,   ec: 1'b1, eo: 1'b0};

    i4.start = 0; i4.sub = 0; i4.a = '0; i4.b = '0;
    i8.start = 0; i8.sub = 0; i8.a = '0; i8.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(i4.busy), 0);
    chk("reset_done", longint'(i4.done), 0);
    chk("reset_sum", longint'(i4.sum), 0);
    chk("reset_flags", longint'({i4.cout, i4.ovf}), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op4(tbl[i].a, tbl[i].b, tbl[i].s, rs, rc, ro, edges);
      chk($sformatf("vec%0d_edges", i), edges, 5);
      chk($sformatf("vec%0d_sum", i), rs, tbl[i].es);
      chk($sformatf("vec%0d_cout", i), longint'(rc), longint'(tbl[i].ec));
      chk($sformatf("vec%0d_ovf", i), longint'(ro), longint'(tbl[i].eo));
      chk($sformatf("vec%0d_busy_at_done", i), longint'(i4.busy), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), longint'(i4.done), 0);
      chk($sformatf("vec%0d_sum_hold", i), longint'(i4.sum), tbl[i].es);
    end

    // Start pulsed during RUN must be ignored
    @(negedge clk);
    i4.start = 1; i4.a = 4'sd3; i4.b = 4'sd1; i4.sub = 0;
    @(posedge clk); #1; i4.start = 0;
    @(posedge clk); #1;
    i4.start = 1; i4.a = 4'sd7; i4.b = 4'sd7; i4.sub = 1;
    @(posedge clk); #1; i4.start = 0;
    edges = 2;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (i4.done) break;
    end
    chk("ignore_start_edges", edges, 5);
    chk("ignore_start_sum", longint'(i4.sum), 4);

    // Reset asserted mid-RUN aborts with no done pulse
    @(negedge clk);
    i4.start = 1; i4.a = 4'sd5; i4.b = 4'sd3; i4.sub = 0;
    @(posedge clk); #1; i4.start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrun_rst_busy", longint'(i4.busy), 0);
    chk("midrun_rst_sum", longint'(i4.sum), 0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (i4.done || i4.busy) seen_done++;
    end
    chk("midrun_no_done", seen_done, 0);
    chk("midrun_outputs", longint'({i4.sum, i4.cout, i4.ovf}), 0);

    // Random W=4 operations
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rsub = 1'($urandom);
      model(4, longint'(ra), longint'(rb), rsub, es, ec, eo);
      op4(ra, rb, rsub, rs, rc, ro, edges);
      chk($sformatf("rnd4_%0d_a%0d_b%0d_s%0d", i, ra, rb, rsub), rs, es);
      chk($sformatf("rnd4_%0d_flags", i), longint'({rc, ro}), longint'({ec, eo}));
    end

    // W=8 directed then random
    op8(8'sd100, 8'sd100, 1'b0, rs, rc, ro, edges);
    chk("w8_edges", edges, 9);
    chk("w8_sum", rs, 200);
    chk("w8_flags", longint'({rc, ro}), longint'({1'b0, 1'b1}));

    for (int i = 0; i < 20; i++) begin
      qa = 8'($urandom); qb = 8'($urandom); rsub = 1'($urandom);
      model(8, longint'(qa), longint'(qb), rsub, es, ec, eo);
      op8(qa, qb, rsub, rs, rc, ro, edges);
      chk($sformatf("rnd8_%0d_a%0d_b%0d_s%0d", i, qa, qb, rsub), rs, es);
      chk($sformatf("rnd8_%0d_flags", i), longint'({rc, ro}), longint'({ec, eo}));
    end

    // Start held high through DONE launches the next op back-to-back
    @(negedge clk);
    i8.start = 1; i8.a = 8'sd100; i8.b = 8'sd100; i8.sub = 0;
    @(posedge clk); #1;
    edges = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (i8.done) break;
    end
    chk("b2b_first_edges", edges, 9);
    chk("b2b_first_sum", longint'(i8.sum), 200);
    i8.a = -8'sd50; i8.b = 8'sd30; i8.sub = 1;
    @(posedge clk); #1;
    i8.start = 0;
    chk("b2b_busy", longint'(i8.busy), 1);
    chk("b2b_done_drop", longint'(i8.done), 0);
    edges = 1;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (i8.done) break;
    end
    chk("b2b_period", edges, 10);
    chk("b2b_second_sum", longint'(i8.sum), -80);
    chk("b2b_second_flags", longint'({i8.cout, i8.ovf}), longint'({1'b1, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
